fpa_pipe: RTL and testbench
===========================

Name: fpa_pipe

Overview:
- Pipelined IEEE-754 single-precision floating-point adder.
- Accepts one operand pair per clock and returns the sum a fixed 6 cycles later.
- Internally it unpacks, aligns (right barrel shift), adds/subtracts, normalizes and packs.
- Used as the floating-point add datapath in the arithmetic unit.

Parameters:
- None. Latency is fixed at 6 cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- a  input  32  operand A, IEEE-754 binary32 (bit 31 sign, 30:23 exponent, 22:0 fraction)
- b  input  32  operand B, same format
- c  output  32  registered sum a+b, same format

Behaviour:
- Reset: while rst=0, all pipeline registers clear asynchronously and c=0x00000000. The first valid result appears 6 rising edges after rst deasserts and an input is applied.
- Throughput and latency: one operation per cycle, no stalls, no handshake. An input sampled on edge N appears on c after edge N+5, i.e. it is valid during cycle N+6 counting the sampling edge as 1.
- Stage 1: register a and b.
- Stage 2, unpack:
  - Mantissa is 24 bits: hidden bit 1 for normals. Subnormals use hidden bit 0 with effective exponent 1.
  - Swap operands so the first has the larger magnitude (exponent, then mantissa). The larger operand's sign becomes the result sign.
- Stage 3: compute exponent difference d = expA - expB (8-bit unsigned).
- Stage 4: right barrel shift of the smaller mantissa by d, with 3 extra low bits (guard/round/sticky). If d >= 27, the shifted value is 0 and only the sticky bit reflects it.
- Stage 5, combine: signs equal -> add mantissas (25-bit result with carry); signs differ -> subtract smaller from larger (never negative).
- Stage 6, normalize and pack, then register to c:
  - On carry, shift right 1 and exponent +1.
  - Otherwise, leading-zero count and left shift until the hidden bit is set, stopping when the exponent reaches 1 (result stays subnormal, exponent field 0).
  - Default rounding is truncation (round toward zero).
- Special cases, checked on the raw registered inputs and overriding arithmetic:
  - Either operand NaN -> 0x7FC00000.
  - +Inf + -Inf -> 0x7FC00000.
  - One or both operands Inf (same sign) -> that Inf.
  - Exact cancellation (equal magnitude, opposite sign) -> +0 (0x00000000).
  - -0 + -0 -> 0x80000000.
  - Exponent overflow after normalization -> Inf with the result sign (0x7F800000 or 0xFF800000).
- Back-to-back operations do not interact. Asserting reset mid-stream discards all in-flight operations.

Optional Feature:
- Macro ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using the guard/round/sticky bits after normalization.
  - If rounding causes mantissa overflow, renormalize (exponent +1).
  - A rounded result that overflows the exponent produces Inf.
- Not defined: truncation (round toward zero); guard/round/sticky bits are ignored.
- Latency is 6 cycles in both builds.

Test Plan:
- Reset: hold rst=0 with inputs toggling -> c=0x00000000 throughout. Release rst, apply a=0x40000000 (2.0), b=0x41200000 (10.0) -> c=0x41400000 (12.0) exactly 6 cycles later.
- Streaming, one pair per cycle; results must appear on consecutive cycles in order:
  - 0x4415C000 (599) + 0x41200000 (10) -> 0x44184000 (609)
  - 0x447A0000 (1000) + 0x47C34F80 (99999) -> 0x47C54380 (100999)
  - 0x40000000 + 0x40000000 -> 0x40800000 (4.0)
- Cancellation and subtraction:
  - 0x40A00000 + 0xC0A00000 -> 0x00000000
  - 0x41200000 + 0xC0000000 (10 - 2) -> 0x41000000 (8.0)
- Specials:
  - 0x7F800000 + 0x3F800000 -> 0x7F800000
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000
  - 0x7FC00001 + anything -> 0x7FC00000
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000
- Subnormals: 0x00000001 + 0x00000001 -> 0x00000002; 0x00400000 + 0x00400000 -> 0x00800000 (promotes to normal).
- Rounding: 0x4B800000 (2^24) + 0x3F800000 (1.0) -> 0x4B800000 in both builds. 0x4B800001 + 0x3F800000 -> 0x4B800001 truncating, 0x4B800002 with ROUND_NEAREST_EN.

Source files
------------

// File: rtl/fpa_pipe.sv
// fpa_pipe: six-stage IEEE-754 binary32 adder (register, unpack, align, add, normalize/pack).
// Build with ROUND_NEAREST_EN defined for round-to-nearest-even; default build truncates.
module fpa_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] c
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd27;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(26 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   logic [31:0] a_q, b_q;
   logic        s2_sgn, s2_sub;
   logic [7:0]  s2_el, s2_es;
   logic [23:0] s2_ml, s2_ms;
   logic [32:0] s2_sp;
   logic        s3_sgn, s3_sub;
   logic [7:0]  s3_el, s3_d;
   logic [23:0] s3_ml, s3_ms;
   logic [32:0] s3_sp;
   logic        s4_sgn, s4_sub;
   logic [7:0]  s4_el;
   logic [26:0] s4_lx, s4_sx;
   logic [32:0] s4_sp;
   logic        s5_sgn;
   logic [7:0]  s5_el;
   logic [27:0] s5_sum;
   logic [32:0] s5_sp;

   // Unpack: subnormals get hidden bit 0 and effective exponent 1.
   logic [7:0]  ea, eb, eea, eeb;
   logic [23:0] ma, mb;
   logic        a_nan, b_nan, a_inf, b_inf, a_big;
   logic [32:0] sp_d;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      ea    = a_q[30:23];
      eb    = b_q[30:23];
      ma    = {(ea != 8'd0), a_q[22:0]};
      mb    = {(eb != 8'd0), b_q[22:0]};
      eea   = (ea == 8'd0) ? 8'd1 : ea;
      eeb   = (eb == 8'd0) ? 8'd1 : eb;
      a_nan = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
      b_nan = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
      a_inf = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
      b_inf = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
      a_big = {eea, ma} >= {eeb, mb};
      sp_d  = 33'd0;
      if (a_nan || b_nan)
         sp_d = {1'b1, QNAN};
      else if (a_inf && b_inf && (a_q[31] != b_q[31]))
         sp_d = {1'b1, QNAN};
      else if (a_inf)
         sp_d = {1'b1, a_q};
      else if (b_inf)
         sp_d = {1'b1, b_q};
      else if ((a_q == 32'h8000_0000) && (b_q == 32'h8000_0000))
         sp_d = {1'b1, 32'h8000_0000};
   end

   // Alignment: bits shifted past the sticky position collapse into bit 0.
   logic [26:0] ext, sh_x;
   logic        lost;

   always_comb begin
      ext  = {s3_ms, 3'b000};
      sh_x = 27'd0;
      lost = 1'b0;
      if (s3_d >= 8'd27) begin
         sh_x[0] = |s3_ms;
      end else begin
         sh_x    = ext >> s3_d[4:0];
         lost    = |(ext & ~({27{1'b1}} << s3_d[4:0]));
         sh_x[0] = sh_x[0] | lost;
      end
   end

   // Normalize, round and pack; left shift stops at exponent 1 so results stay subnormal.
   logic [26:0] norm;
   logic [9:0]  e_n, lim, sh;
   logic [4:0]  lz;
   logic [24:0] mant;
   logic        sgn;
   logic [31:0] c_d;
`ifdef ROUND_NEAREST_EN
   logic        rnd;
`endif

   always_comb begin
      lz  = lzc27(s5_sum[26:0]);
      lim = {2'b00, s5_el} - 10'd1;
      sh  = 10'd0;
      if (s5_sum[27]) begin
         norm = {s5_sum[27:2], s5_sum[1] | s5_sum[0]};
         e_n  = {2'b00, s5_el} + 10'd1;
      end else begin
         sh   = ({5'd0, lz} > lim) ? lim : {5'd0, lz};
         norm = s5_sum[26:0] << sh;
         e_n  = {2'b00, s5_el} - sh;
      end
`ifdef ROUND_NEAREST_EN
      rnd  = norm[2] & (norm[3] | norm[1] | norm[0]);
      mant = {1'b0, norm[26:3]} + {24'd0, rnd};
`else
      mant = {1'b0, 24'(norm >> 3)};
`endif
      if (mant[24]) begin
         mant = {1'b0, mant[24:1]};
         e_n  = e_n + 10'd1;
      end
      sgn = s5_sgn & (mant != 25'd0);
      if (s5_sp[32])
         c_d = s5_sp[31:0];
      else if (e_n >= 10'd255)
         c_d = {sgn, 8'hFF, 23'd0};
      else
         c_d = {sgn, (mant[23] ? e_n[7:0] : 8'd0), mant[22:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         s2_sgn <= 1'b0;
         s2_sub <= 1'b0;
         s2_el  <= 8'd0;
         s2_es  <= 8'd0;
         s2_ml  <= 24'd0;
         s2_ms  <= 24'd0;
         s2_sp  <= 33'd0;
         s3_sgn <= 1'b0;
         s3_sub <= 1'b0;
         s3_el  <= 8'd0;
         s3_d   <= 8'd0;
         s3_ml  <= 24'd0;
         s3_ms  <= 24'd0;
         s3_sp  <= 33'd0;
         s4_sgn <= 1'b0;
         s4_sub <= 1'b0;
         s4_el  <= 8'd0;
         s4_lx  <= 27'd0;
         s4_sx  <= 27'd0;
         s4_sp  <= 33'd0;
         s5_sgn <= 1'b0;
         s5_el  <= 8'd0;
         s5_sum <= 28'd0;
         s5_sp  <= 33'd0;
         c      <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
         a_q    <= a;
         b_q    <= b;
         s2_sgn <= a_big ? a_q[31] : b_q[31];
         s2_sub <= a_q[31] ^ b_q[31];
         s2_el  <= a_big ? eea : eeb;
         s2_es  <= a_big ? eeb : eea;
         s2_ml  <= a_big ? ma : mb;
         s2_ms  <= a_big ? mb : ma;
         s2_sp  <= sp_d;
         s3_sgn <= s2_sgn;
         s3_sub <= s2_sub;
         s3_el  <= s2_el;
         s3_d   <= s2_el - s2_es;
         s3_ml  <= s2_ml;
         s3_ms  <= s2_ms;
         s3_sp  <= s2_sp;
         s4_sgn <= s3_sgn;
         s4_sub <= s3_sub;
         s4_el  <= s3_el;
         s4_lx  <= {s3_ml, 3'b000};
         s4_sx  <= sh_x;
         s4_sp  <= s3_sp;
         s5_sgn <= s4_sgn;
         s5_el  <= s4_el;
         s5_sum <= s4_sub ? ({1'b0, s4_lx} - {1'b0, s4_sx}) : ({1'b0, s4_lx} + {1'b0, s4_sx});
         s5_sp  <= s4_sp;
         c      <= c_d;
      end
   end
endmodule

// File: tb/tb_fpa_pipe.sv
// Scoreboard bench for fpa_pipe: directed vectors plus random operands checked against an
// exact-arithmetic reference model; follows ROUND_NEAREST_EN like the design.
module tb_fpa_pipe;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef ROUND_NEAREST_EN
   localparam bit          RNE     = 1'b1;
   localparam logic [31:0] RND_EXP = 32'h4B80_0002;
`else
   localparam bit          RNE     = 1'b0;
   localparam logic [31:0] RND_EXP = 32'h4B80_0001;
`endif

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } vec_t;

   localparam vec_t DIR [0:15] = '{
      '{32'h4000_0000, 32'h4120_0000, 32'h4140_0000},
      '{32'h4415_C000, 32'h4120_0000, 32'h4418_4000},
      '{32'h447A_0000, 32'h47C3_4F80, 32'h47C5_4380},
      '{32'h4000_0000, 32'h4000_0000, 32'h4080_0000},
      '{32'h40A0_0000, 32'hC0A0_0000, 32'h0000_0000},
      '{32'h4120_0000, 32'hC000_0000, 32'h4100_0000},
      '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000},
      '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000},
      '{32'h7FC0_0001, 32'h1234_5678, 32'h7FC0_0000},
      '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000},
      '{32'h0000_0001, 32'h0000_0001, 32'h0000_0002},
      '{32'h0040_0000, 32'h0040_0000, 32'h0080_0000},
      '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000},
      '{32'h4B80_0001, 32'h3F80_0000, RND_EXP},
      '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
      '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000}
   };

   localparam logic [31:0] SPC [0:5] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                                         32'h0000_0000, 32'h8000_0000, 32'h7F7F_FFFF};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [31:0] c;
   logic        issue = 1'b0;
   logic [5:0]  vpipe;
   int          n_tests = 0;
   int          n_fail = 0;
   vec_t        sb[$];

   fpa_pipe dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c));

   always #5 clk = ~clk;

   // Tracks which cycles carry a result, independent of the design's internals.
   always @(posedge clk or negedge rst) begin
      if (!rst) vpipe <= 6'd0;
      else      vpipe <= {vpipe[4:0], issue};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h required %08h", name, act, req);
      end
   endtask

   // Exact sum of the two operands, then a single rounding to binary32.
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      int           ex, ey, el, es, base, p, sh, er;
      logic [127:0] vx, vy, mag, m, rem, half;
      logic [23:0]  mx, my;
      logic         sx, sy, sr;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      sx = x[31];
      sy = y[31];
      if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return QNAN;
      if (ex == 255 && ey == 255) return (sx == sy) ? x : QNAN;
      if (ex == 255) return x;
      if (ey == 255) return y;
      mx = {(ex != 0), x[22:0]};
      my = {(ey != 0), y[22:0]};
      if (ex == 0) ex = 1;
      if (ey == 0) ey = 1;
      el   = (ex > ey) ? ex : ey;
      es   = (ex > ey) ? ey : ex;
      base = (el - 40 > es) ? el - 40 : es;
      // An operand far below the other only matters as a nonzero sliver.
      vx = (ex < base) ? ((mx != 0) ? 128'd1 : 128'd0) : (128'(mx) << (ex - base));
      vy = (ey < base) ? ((my != 0) ? 128'd1 : 128'd0) : (128'(my) << (ey - base));
      if (sx == sy) begin
         mag = vx + vy;
         sr  = sx;
      end else if (vx >= vy) begin
         mag = vx - vy;
         sr  = sx;
      end else begin
         mag = vy - vx;
         sr  = sy;
      end
      if (mag == 0) return (sx && sy) ? 32'h8000_0000 : 32'h0000_0000;
      p = 127;
      while (!mag[p]) p--;
      sh = p - 23;
      er = base + sh;
      if (er < 1) begin
         sh = sh + (1 - er);
         er = 1;
      end
      if (sh > 0) begin
         m    = mag >> sh;
         rem  = mag & ((128'd1 << sh) - 128'd1);
         half = 128'd1 << (sh - 1);
      end else begin
         m    = mag << (-sh);
         rem  = 128'd0;
         half = 128'd1;
      end
      if (RNE && ((rem > half) || (rem == half && m[0]))) m = m + 128'd1;
      if (m[24]) begin
         m  = m >> 1;
         er = er + 1;
      end
      if (er >= 255) return {sr, 8'hFF, 23'd0};
      return {sr, (m[23] ? 8'(er) : 8'd0), m[22:0]};
   endfunction

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] want);
      @(posedge clk);
      #2;
      a     = x;
      b     = y;
      issue = 1'b1;
      sb.push_back('{x, y, want});
   endtask

   task automatic idle();
      @(posedge clk);
      #2;
      issue = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
   endtask

   // Monitor: c must be zero under reset, otherwise compare each scheduled result in order.
   initial begin
      vec_t t;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("reset", c, 32'h0000_0000);
         end else if (vpipe[5]) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected: result %08h with empty scoreboard", c);
            end else begin
               t = sb.pop_front();
               check($sformatf("%08h+%08h", t.a, t.b), c, t.c);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] x, y;
      int          k, e;
      #1 rst = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #2;
         a = $urandom;
         b = $urandom;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;

      foreach (DIR[i]) drive(DIR[i].a, DIR[i].b, DIR[i].c);
      drain();

      // In-flight work is discarded by a mid-stream reset.
      repeat (3) begin
         x = $urandom;
         y = $urandom;
         drive(x, y, ref_add(x, y));
      end
      @(posedge clk);
      #2;
      rst   = 1'b0;
      issue = 1'b0;
      sb.delete();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      drive(32'h4000_0000, 32'h4120_0000, 32'h4140_0000);

      for (int n = 0; n < 400; n++) begin
         k = int'($urandom_range(0, 9));
         x = $urandom;
         case (k)
            0, 1, 2: y = $urandom;
            3, 4, 5: begin
               e = int'(x[30:23]) + int'($urandom_range(0, 6)) - 3;
               if (e < 0) e = 0;
               if (e > 254) e = 254;
               y = {1'($urandom), 8'(e), 23'($urandom)};
            end
            6: begin
               x[30:23] = 8'd0;
               y = {1'($urandom), 8'($urandom_range(0, 1)), 23'($urandom)};
            end
            7: y = x ^ 32'h8000_0000;
            8: y = {~x[31], x[30:3], 3'($urandom)};
            default: begin
               x = SPC[$urandom_range(0, 5)];
               y = ($urandom_range(0, 1) == 0) ? SPC[$urandom_range(0, 5)] : $urandom;
            end
         endcase
         drive(x, y, ref_add(x, y));
         if ($urandom_range(0, 7) == 0) idle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
